// File: rtl/alu_pkg.sv
// Shared definitions for the accumulator sequencer and its 4-bit ALU.
//   DW       : datapath width (4 bits)
//   OP_*     : command opcodes; 000-100 double as the ALU select encoding
//   state_t  : sequencer state encoding (IDLE, EXEC, MUL, RESP)
package alu_pkg;

  localparam int DW = 4;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_LOAD = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_CLR  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_RESP = 2'd3
  } state_t;

endpackage

// File: rtl/alu_4bits.sv
// Combinational 4-bit ALU.
//   sel    in  3 : 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR (others give 0)
//   a, b   in  4 : operands
//   result out 4 : low 4 bits of the operation
//   carry  out 1 : ADD carry-out / SUB borrow (bit 4 of the 5-bit a-b); 0 for logic ops
//   zero   out 1 : result == 0
module alu_4bits
  import alu_pkg::*;
(
  input  logic [2:0]    sel,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] result,
  output logic          carry,
  output logic          zero
);

  logic [DW:0] wide;

  always_comb begin
    wide = '0;
    case (sel)
      OP_ADD:  wide = {1'b0, a} + {1'b0, b};
      OP_SUB:  wide = {1'b0, a} - {1'b0, b};
      OP_AND:  wide = {1'b0, a & b};
      OP_OR:   wide = {1'b0, a | b};
      OP_XOR:  wide = {1'b0, a ^ b};
      default: wide = '0;
    endcase
    result = wide[DW-1:0];
    carry  = wide[DW];
    zero   = (wide[DW-1:0] == '0);
  end

endmodule

// File: rtl/alu_acc_sequencer.sv
// Accumulator command sequencer around alu_4bits.
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high; the producer keeps its payload stable while valid is high and not yet
// accepted. Commands use cmd_valid/cmd_ready, responses use rsp_valid/rsp_ready.
//   clk, rst            : clock, asynchronous active-high reset
//   cmd_valid/cmd_ready : command handshake (cmd_ready only in IDLE, rst low)
//   cmd_op, cmd_b       : opcode and operand B, sampled at the handshake
//   rsp_valid/rsp_ready : response handshake
//   rsp_carry, rsp_zero : flags of the last completed command
//   acc                 : accumulator
//   busy                : state is not IDLE
module alu_acc_sequencer
  import alu_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [DW-1:0] cmd_b,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_carry,
  output logic          rsp_zero,
  output logic [DW-1:0] acc,
  output logic          busy
);

  state_t        state;
  logic [2:0]    op_q;
  logic [DW-1:0] b_q;
  logic [DW-1:0] mcand;
  logic [DW-1:0] cnt;
  logic [DW-1:0] prod;
  logic          sticky;

  logic [2:0]    alu_sel;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [DW-1:0] alu_result;
  logic          alu_carry;
  logic          alu_zero_unused;  // rsp_zero is taken from the new accumulator

  logic [DW-1:0] exec_acc;
  logic          exec_carry;

  // MUL reuses the adder: prod accumulates mcand once per remaining count.
  always_comb begin
    alu_sel = op_q;
    alu_a   = acc;
    alu_b   = b_q;
    if (state == ST_MUL) begin
      alu_sel = OP_ADD;
      alu_a   = prod;
      alu_b   = mcand;
    end
  end

  alu_4bits u_alu (
    .sel    (alu_sel),
    .a      (alu_a),
    .b      (alu_b),
    .result (alu_result),
    .carry  (alu_carry),
    .zero   (alu_zero_unused)
  );

  always_comb begin
    exec_acc   = alu_result;
    exec_carry = alu_carry;
    case (op_q)
      OP_LOAD: begin
        exec_acc   = b_q;
        exec_carry = 1'b0;
      end
      OP_CLR: begin
        exec_acc   = '0;
        exec_carry = 1'b0;
      end
      default: ;
    endcase
  end

  assign cmd_ready = (state == ST_IDLE) && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      op_q      <= OP_ADD;
      b_q       <= '0;
      mcand     <= '0;
      cnt       <= '0;
      prod      <= '0;
      sticky    <= 1'b0;
      acc       <= '0;
      rsp_carry <= 1'b0;
      rsp_zero  <= 1'b1;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_q <= cmd_op;
            b_q  <= cmd_b;
            busy <= 1'b1;
            if (cmd_op == OP_MUL) begin
              mcand  <= acc;
              cnt    <= cmd_b;
              prod   <= '0;
              sticky <= 1'b0;
              state  <= ST_MUL;
            end else begin
              state <= ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          acc       <= exec_acc;
          rsp_carry <= exec_carry;
          rsp_zero  <= (exec_acc == '0);
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_MUL: begin
          if (cnt != '0) begin
            prod   <= alu_result;
            sticky <= sticky | alu_carry;
            cnt    <= cnt - 1'b1;
          end else begin
            acc       <= prod;
            rsp_carry <= sticky;
            rsp_zero  <= (prod == '0);
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_acc_sequencer.sv
module tb_alu_acc_sequencer;
  import alu_pkg::*;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [2:0]    cmd_op = 3'b000;
  logic [DW-1:0] cmd_b = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic          rsp_carry;
  logic          rsp_zero;
  logic [DW-1:0] acc;
  logic          busy;

  alu_acc_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_b     (cmd_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_carry (rsp_carry),
    .rsp_zero  (rsp_zero),
    .acc       (acc),
    .busy      (busy)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [5:0] exp_q[$];   // {carry, zero, acc[3:0]}
  int         lat_q[$];
  int         m_acc = 0;  // reference accumulator

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  // Reference model: plain arithmetic on integers.
  task automatic model(input logic [2:0] op, input int b, output logic [5:0] res, output int lat);
    int  r;
    bit  c;
    c   = 1'b0;
    lat = 1;
    case (op)
      OP_ADD:  begin r = m_acc + b;  c = (r > 15); end
      OP_SUB:  begin r = m_acc - b;  c = (m_acc < b); if (r < 0) r += 16; end
      OP_AND:  r = m_acc & b;
      OP_OR:   r = m_acc | b;
      OP_XOR:  r = m_acc ^ b;
      OP_LOAD: r = b;
      OP_MUL:  begin r = m_acc * b;  c = (r > 15); lat = b + 1; end
      default: r = 0;
    endcase
    m_acc = r % 16;
    res = {c, (m_acc == 0), 4'(m_acc)};
  endtask

  // ---------------- driver tasks (enter/leave on a falling edge) ----------------
  task automatic issue(input logic [2:0] op, input logic [3:0] b);
    logic [5:0] res;
    int lat;
    int n;
    cmd_op    = op;
    cmd_b     = b;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    check_val("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    model(op, int'(b), res, lat);
    exp_q.push_back(res);
    lat_q.push_back(lat);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = 3'($urandom);   // must be ignored outside the handshake
    cmd_b     = 4'($urandom);
    check_val("busy_after_hs", 32'(busy), 32'd1);
  endtask

  task automatic wait_rsp();
    logic [5:0] e;
    int el;
    int lat;
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    e  = exp_q.pop_front();
    el = lat_q.pop_front();
    check_val("rsp_latency", 32'(lat), 32'(el));
    check_val("rsp_result", 32'({rsp_carry, rsp_zero, acc}), 32'(e));
    check_val("rsp_cmd_ready", 32'(cmd_ready), 32'd0);
  endtask

  task automatic release_rsp(input int hold);
    logic [5:0] held;
    held = {rsp_carry, rsp_zero, acc};
    rsp_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_val("hold_state", 32'({rsp_valid, busy, cmd_ready}), 32'b110);
      check_val("hold_result", 32'({rsp_carry, rsp_zero, acc}), 32'(held));
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check_val("back_to_idle", 32'({rsp_valid, busy, cmd_ready}), 32'b001);
  endtask

  task automatic run_cmd(input logic [2:0] op, input logic [3:0] b, input int hold);
    issue(op, b);
    wait_rsp();
    release_rsp(hold);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val(tag, 32'({acc, rsp_carry, rsp_zero, rsp_valid, busy, cmd_ready}),
              32'({4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // reset
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset_state");
    rst = 1'b0;
    #1;
    check_val("ready_after_reset", 32'(cmd_ready), 32'd1);
    @(negedge clk);

    // directed arithmetic
    run_cmd(OP_LOAD, 4'd5, 0);
    run_cmd(OP_ADD,  4'd3, 0);
    check_val("acc_8", 32'(acc), 32'd8);
    run_cmd(OP_ADD,  4'd9, 1);
    check_val("add_wrap", 32'({rsp_carry, acc}), 32'({1'b1, 4'd1}));
    run_cmd(OP_LOAD, 4'd2, 0);
    run_cmd(OP_SUB,  4'd3, 0);
    check_val("sub_borrow", 32'({rsp_carry, acc}), 32'({1'b1, 4'd15}));
    run_cmd(OP_XOR,  4'd15, 0);
    run_cmd(OP_AND,  4'd6, 0);
    run_cmd(OP_OR,   4'd10, 0);

    // multiply
    run_cmd(OP_LOAD, 4'd3, 0);
    run_cmd(OP_MUL,  4'd5, 0);
    run_cmd(OP_LOAD, 4'd6, 0);
    run_cmd(OP_MUL,  4'd3, 0);
    run_cmd(OP_MUL,  4'd0, 0);
    run_cmd(OP_LOAD, 4'd15, 0);
    run_cmd(OP_MUL,  4'd15, 0);

    // backpressure with a command held during RESP: CLR must wait for IDLE
    issue(OP_LOAD, 4'd9);
    cmd_valid = 1'b1;
    cmd_op    = OP_CLR;
    cmd_b     = 4'd7;
    wait_rsp();
    release_rsp(5);
    issue(OP_CLR, 4'd7);
    wait_rsp();
    release_rsp(0);
    check_val("clr_flags", 32'({rsp_carry, rsp_zero, acc}), 32'({1'b0, 1'b1, 4'd0}));

    // reset in the middle of MUL 15 (cnt reaches 7 eight edges after accept)
    run_cmd(OP_LOAD, 4'd3, 0);
    issue(OP_MUL, 4'd15);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_mul_reset");
    exp_q.delete();
    lat_q.delete();
    m_acc = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_val("post_reset_rsp", 32'({rsp_valid, busy, acc}), 32'({1'b0, 1'b0, 4'd0}));
    run_cmd(OP_LOAD, 4'd4, 0);
    check_val("load_after_reset", 32'(acc), 32'd4);

    // cmd_valid pulse while in reset is ignored
    rst       = 1'b1;
    cmd_valid = 1'b1;
    cmd_op    = OP_LOAD;
    cmd_b     = 4'd7;
    m_acc     = 0;
    #1;
    check_val("ready_in_reset", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_val("pulse_ignored", 32'({busy, rsp_valid, rsp_zero, acc}), 32'({1'b0, 1'b0, 1'b1, 4'd0}));

    // randomized commands
    for (int i = 0; i < 60; i++) begin
      run_cmd(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_acc_sequencer.md
# alu_acc_sequencer

Accumulator-based command sequencer wrapped around the team's 4-bit ALU datapath (`alu_4bits`). It accepts one opcode/operand command at a time over a valid/ready interface and applies it to an internal 4-bit accumulator. Multiply is run as a multi-cycle loop of repeated ALU additions. The block returns the result and flags over a valid/ready response interface, and sits between the tile's I/O decode logic and the ALU.

## Interface
Parameters: none; all widths are fixed at 4-bit data and 3-bit opcode.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: a command is presented.
- `cmd_ready` out 1: the block accepts a command. High only in IDLE and only while `rst`=0.
- `cmd_op` in 3: opcode. 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 LOAD, 110 MUL, 111 CLR.
- `cmd_b` in 4: operand B.
- `rsp_valid` out 1: a response is presented.
- `rsp_ready` in 1: the consumer accepts the response.
- `rsp_carry` out 1: carry/borrow/overflow flag of the last completed command.
- `rsp_zero` out 1: high when the accumulator is 0 after the last completed command.
- `acc` out 4: current accumulator value, registered.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- States are IDLE, EXEC, MUL and RESP.
- **IDLE:**
  - Command handshake is `cmd_valid && cmd_ready` at an edge.
  - On the handshake, latch `op` and `b`.
  - For MUL, also latch `mcand=acc`, `cnt=cmd_b`, `prod=0` and `sticky=0`, then go to MUL.
  - For any other opcode, go to EXEC.
- **EXEC (one cycle):** write `acc` and the flags, then go to RESP.
  - ADD, SUB, AND, OR, XOR: `acc <= ALU(sel=op, A=acc, B=b).result`, `rsp_carry <= ALU carry`. For SUB the carry is the borrow, i.e. bit 4 of the 5-bit `A-B`.
  - LOAD: `acc <= b`, `rsp_carry <= 0`.
  - CLR: `acc <= 0`, `rsp_carry <= 0`.
  - `rsp_zero <= (new acc == 0)` for every opcode.
- **MUL:** the ALU is driven with sel=000, A=`prod`, B=`mcand`.
  - If `cnt != 0`: `prod <= result`, `sticky <= sticky | carry`, `cnt <= cnt-1`.
  - If `cnt == 0`: `acc <= prod`, `rsp_carry <= sticky`, `rsp_zero <= (prod==0)`, then go to RESP.
  - The result is the low 4 bits of the product. `rsp_carry` flags any overflow past 4 bits.
- **RESP:**
  - `rsp_valid`=1; `acc` and the flags are held stable.
  - On `rsp_valid && rsp_ready` at an edge, go to IDLE.
  - `rsp_ready` is ignored in every other state.
- **ALU select muxing:** the ALU `sel` is driven from the latched `op` in EXEC and forced to 000 in MUL. In IDLE and RESP the ALU output is unused.
- **Reset** (async, any state, including mid-MUL): the state goes to IDLE and the partial product is discarded.
  - `acc`=0, `rsp_carry`=0, `rsp_zero`=1, `rsp_valid`=0, `busy`=0, `cmd_ready`=0 while `rst` is high.
  - `cnt`, `prod`, `mcand` and `sticky` clear to 0.

## Timing
- Let the handshake occur at edge k.
- Single-cycle ops: `acc`, the flags and `rsp_valid` update at edge k+1.
- MUL with operand b: the result appears at edge k+b+1. This gives 1 cycle for b=0 and at most 16 cycles for b=15.
- `rsp_valid` stays high until the edge where `rsp_ready`=1. The earliest response accept is edge k+2 for single-cycle ops.
- `cmd_ready` rises in the cycle after the response handshake. No command is accepted in the same cycle as a response handshake.
- Maximum throughput is one single-cycle command per 3 cycles.
- `cmd_op` and `cmd_b` are sampled only at the handshake edge; changes at other times have no effect.
- `cmd_ready` is combinational from the state and `rst`. All other outputs are registered.

## Structure
- Shared package `alu_pkg` holds:
  - opcode localparams `OP_ADD` … `OP_CLR`, with the values 000–100 identical to the ALU `sel` encoding;
  - the state encoding;
  - data width `DW=4`.
- One sub-module instance: `alu_4bits`. Its `zero` output is unused, because `rsp_zero` is recomputed from the new accumulator value.

## Test plan
- After reset: `acc`=0, `rsp_zero`=1, `busy`=0. Then LOAD 5, ADD 3 → each response arrives 1 edge after its handshake; final `acc`=8, carry=0, zero=0.
- `acc`=8, ADD 9 → `acc`=1, carry=1. Then LOAD 2, SUB 3 → `acc`=15, carry=1. Then XOR 15 → `acc`=0, zero=1, carry=0.
- LOAD 3, MUL 5 → `rsp_valid` at edge k+6, `acc`=15, carry=0. LOAD 6, MUL 3 → `acc`=2, carry=1. MUL 0 → `acc`=0, zero=1, latency 1 edge.
- Backpressure: hold `rsp_ready`=0 for 5 cycles → `rsp_valid`, `acc` and the flags are stable throughout and `cmd_ready`=0. Release → IDLE on the next edge. Verify that a `cmd_valid` held during RESP is accepted only after returning to IDLE.
- Assert `rst` for 1 cycle during a MUL 15 (at cnt=7) → immediate IDLE, `acc`=0, `rsp_valid`=0. A following LOAD 4 completes normally with `acc`=4.
- CLR after `acc`=9 → `acc`=0, zero=1, carry=0. A `cmd_valid` pulse while `rst`=1 is ignored.
